// File: rtl/clock_pkg.sv
// Shared types and constants for the decade clock set-mode controller.
// Field limits, the power-on date and the month-length helper live here.
package clock_pkg;

  typedef enum logic [3:0] {
    StInit,
    StRun,
    StSetHour,
    StSetMin,
    StSetSec,
    StSetYear,
    StSetMonth,
    StSetDay,
    StCommit
  } state_e;

  localparam logic [5:0]  SecMax   = 6'd59;
  localparam logic [5:0]  MinMax   = 6'd59;
  localparam logic [4:0]  HourMax  = 5'd23;
  localparam logic [3:0]  MonthMax = 4'd12;
  localparam logic [13:0] YearMax  = 14'd9999;
  localparam logic [3:0]  MonthMin = 4'd1;
  localparam logic [4:0]  DayMin   = 5'd1;

  localparam logic [5:0]  RstSec   = 6'd0;
  localparam logic [5:0]  RstMin   = 6'd0;
  localparam logic [4:0]  RstHour  = 5'd0;
  localparam logic [4:0]  RstDay   = 5'd1;
  localparam logic [3:0]  RstMonth = 4'd1;
  localparam logic [13:0] RstYear  = 14'd2024;

  // Out-of-range months fall back to 31 so a bogus captured month never shrinks the day.
  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [13:0] year);
    logic [4:0] dim;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

  function automatic logic [2:0] field_of(input state_e st);
    logic [2:0] sel;
    case (st)
      StSetHour:  sel = 3'd1;
      StSetMin:   sel = 3'd2;
      StSetSec:   sel = 3'd3;
      StSetYear:  sel = 3'd4;
      StSetMonth: sel = 3'd5;
      StSetDay:   sel = 3'd6;
      default:    sel = 3'd0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Counter-side bus: live time/date values in, tick enable and parallel load out.
interface clock_set_ctrl_if;

  logic [5:0]  cur_sec;
  logic [5:0]  cur_min;
  logic [4:0]  cur_hour;
  logic [4:0]  cur_day;
  logic [3:0]  cur_month;
  logic [13:0] cur_year;

  logic        tick_en;
  logic        load;
  logic [5:0]  ld_sec;
  logic [5:0]  ld_min;
  logic [4:0]  ld_hour;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [13:0] ld_year;

  modport master (
    input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
    output tick_en, load, ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year
  );

  modport slave (
    output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
    input  tick_en, load, ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Produces exactly one clk-wide pulse per press; holding the button never repeats.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      prev_q <= sync_q[1];
      pulse  <= sync_q[1] & ~prev_q;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode sequencer for the time/date counter: 1 Hz tick prescaler, two-button field
// editor over shadow registers, and a one-cycle parallel load on commit and after reset.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    inc,
  clock_set_ctrl_if.master        cnt,
  output logic [2:0]              field_sel,
  output logic                    blink
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_HALF - 1);

  logic mode_ev;
  logic inc_ev;

  btn_edge_sync u_mode_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (mode),
    .pulse (mode_ev)
  );

  btn_edge_sync u_inc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (inc),
    .pulse (inc_ev)
  );

  state_e          state_q, state_d;
  logic [PreW-1:0] presc_q;
  logic [BlkW-1:0] bcnt_q;
  logic            tick_en_q, load_q;
  logic [5:0]      ld_sec_q, ld_min_q;
  logic [4:0]      ld_hour_q, ld_day_q;
  logic [3:0]      ld_month_q;
  logic [13:0]     ld_year_q;
  logic [4:0]      dim;
  logic            presc_wrap;

  assign dim        = days_in_month(ld_month_q, ld_year_q);
  assign presc_wrap = (presc_q == PreLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:     state_d = StRun;
      StRun:      if (mode_ev) state_d = StSetHour;
      StSetHour:  if (mode_ev) state_d = StSetMin;
      StSetMin:   if (mode_ev) state_d = StSetSec;
      StSetSec:   if (mode_ev) state_d = StSetYear;
      StSetYear:  if (mode_ev) state_d = StSetMonth;
      StSetMonth: if (mode_ev) state_d = StSetDay;
      StSetDay:   if (mode_ev) state_d = StCommit;
      StCommit:   state_d = StRun;
      default:    state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      presc_q    <= '0;
      bcnt_q     <= '0;
      tick_en_q  <= 1'b0;
      load_q     <= 1'b0;
      field_sel  <= 3'd0;
      blink      <= 1'b0;
      ld_sec_q   <= RstSec;
      ld_min_q   <= RstMin;
      ld_hour_q  <= RstHour;
      ld_day_q   <= RstDay;
      ld_month_q <= RstMonth;
      ld_year_q  <= RstYear;
    end else begin
      state_q   <= state_d;
      field_sel <= field_of(state_d);
      tick_en_q <= 1'b0;
      load_q    <= (state_q == StInit) || (state_d == StCommit);

      case (state_q)
        StInit: begin
          presc_q    <= '0;
          ld_sec_q   <= RstSec;
          ld_min_q   <= RstMin;
          ld_hour_q  <= RstHour;
          ld_day_q   <= RstDay;
          ld_month_q <= RstMonth;
          ld_year_q  <= RstYear;
        end
        StRun: begin
          if (mode_ev) begin
            presc_q    <= '0;
            ld_sec_q   <= cnt.cur_sec;
            ld_min_q   <= cnt.cur_min;
            ld_hour_q  <= cnt.cur_hour;
            ld_day_q   <= cnt.cur_day;
            ld_month_q <= cnt.cur_month;
            ld_year_q  <= cnt.cur_year;
          end else begin
            presc_q   <= presc_wrap ? '0 : presc_q + PreW'(1);
            tick_en_q <= presc_wrap;
          end
        end
        // The commit cycle is the prescaler's first count so the next tick lands TICK_DIV after load.
        StCommit: begin
          presc_q   <= presc_wrap ? '0 : presc_q + PreW'(1);
          tick_en_q <= presc_wrap;
        end
        StSetHour: begin
          presc_q <= '0;
          if (!mode_ev && inc_ev) ld_hour_q <= (ld_hour_q >= HourMax) ? 5'd0 : ld_hour_q + 5'd1;
        end
        StSetMin: begin
          presc_q <= '0;
          if (!mode_ev && inc_ev) ld_min_q <= (ld_min_q >= MinMax) ? 6'd0 : ld_min_q + 6'd1;
        end
        StSetSec: begin
          presc_q <= '0;
          if (!mode_ev && inc_ev) ld_sec_q <= (ld_sec_q >= SecMax) ? 6'd0 : ld_sec_q + 6'd1;
        end
        StSetYear: begin
          presc_q <= '0;
          if (!mode_ev && inc_ev) ld_year_q <= (ld_year_q >= YearMax) ? 14'd0 : ld_year_q + 14'd1;
        end
        StSetMonth: begin
          presc_q <= '0;
          if (mode_ev) begin
            if (ld_day_q > dim) ld_day_q <= dim;
          end else if (inc_ev) begin
            ld_month_q <= (ld_month_q >= MonthMax) ? MonthMin : ld_month_q + 4'd1;
          end
        end
        StSetDay: begin
          presc_q <= '0;
          if (!mode_ev && inc_ev) ld_day_q <= (ld_day_q >= dim) ? DayMin : ld_day_q + 5'd1;
        end
        default: presc_q <= '0;
      endcase

      if (field_of(state_d) == 3'd0 || state_d != state_q) begin
        blink  <= 1'b0;
        bcnt_q <= '0;
      end else if (bcnt_q == BlkLast) begin
        blink  <= ~blink;
        bcnt_q <= '0;
      end else begin
        bcnt_q <= bcnt_q + BlkW'(1);
      end
    end
  end

  assign cnt.tick_en  = tick_en_q;
  assign cnt.load     = load_q;
  assign cnt.ld_sec   = ld_sec_q;
  assign cnt.ld_min   = ld_min_q;
  assign cnt.ld_hour  = ld_hour_q;
  assign cnt.ld_day   = ld_day_q;
  assign cnt.ld_month = ld_month_q;
  assign cnt.ld_year  = ld_year_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: expected load dates are queued as stimulus is driven and
// compared whenever the DUT strobes load; field edits, blink and tick spacing are checked inline.
module tb_clock_set_ctrl;

  localparam int unsigned TickDiv   = 4;
  localparam int unsigned BlinkHalf = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic       inc   = 1'b0;
  logic [2:0] field_sel;
  logic       blink;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .TICK_DIV   (TickDiv),
    .BLINK_HALF (BlinkHalf)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .inc       (inc),
    .cnt       (bus.master),
    .field_sel (field_sel),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [39:0] exp_q[$];

  function automatic logic [39:0] pack_date(input int sec, input int min, input int hour,
                                            input int day, input int month, input int year);
    return {6'(sec), 6'(min), 5'(hour), 5'(day), 4'(month), 14'(year)};
  endfunction

  function automatic logic [39:0] ld_now();
    return {bus.ld_sec, bus.ld_min, bus.ld_hour, bus.ld_day, bus.ld_month, bus.ld_year};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every load strobe consumes the oldest expected date.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.load === 1'b1) begin
      check("load_tick_overlap", bus.tick_en, 0);
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("load_value", ld_now(), exp_q.pop_front());
    end
  end

  task automatic set_cur(input int hour, input int min, input int sec,
                         input int day, input int month, input int year);
    bus.cur_hour  = 5'(hour);
    bus.cur_min   = 6'(min);
    bus.cur_sec   = 6'(sec);
    bus.cur_day   = 5'(day);
    bus.cur_month = 4'(month);
    bus.cur_year  = 14'(year);
  endtask

  // Returns on the first sample where the resulting change is visible.
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    mode = m;
    inc  = i;
    @(negedge clk);
    mode = 1'b0;
    inc  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic count_to_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tick_en !== 1'b1 && n < 20);
    check(tag, n, TickDiv);
  endtask

  task automatic check_blink(input string tag);
    check("set_tick_quiet", bus.tick_en, 0);
    for (int k = 0; k < 6; k++) begin
      check(tag, blink, (k / BlinkHalf) % 2);
      if (k < 5) @(negedge clk);
    end
  endtask

  task automatic clamp_case(input int year, input int exp_day);
    set_cur(10, 20, 30, 31, 1, year);
    repeat (5) press(1'b1, 1'b0);
    check("clamp_sel_month", field_sel, 5);
    press(1'b0, 1'b1);
    check("clamp_month_inc", bus.ld_month, 2);
    press(1'b1, 1'b0);
    check("clamp_sel_day", field_sel, 6);
    check("clamp_day", bus.ld_day, exp_day);
    exp_q.push_back(pack_date(30, 20, 10, exp_day, 2, year));
    press(1'b1, 1'b0);
    check("clamp_commit_load", bus.load, 1);
    count_to_tick("commit_tick_first");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cur(0, 0, 0, 1, 1, 2024);
    repeat (3) @(negedge clk);
    check("rst_load", bus.load, 0);
    check("rst_tick", bus.tick_en, 0);
    check("rst_sel", field_sel, 0);
    check("rst_blink", blink, 0);
    check("rst_ld", ld_now(), pack_date(0, 0, 0, 1, 1, 2024));

    exp_q.push_back(pack_date(0, 0, 0, 1, 1, 2024));
    rst_n = 1'b1;
    @(negedge clk);
    check("init_load", bus.load, 1);
    count_to_tick("init_tick_first");
    count_to_tick("init_tick_period");

    // Capture the all-max date and wrap every field once.
    set_cur(23, 59, 59, 31, 12, 9999);
    press(1'b1, 1'b0);
    check("cap_sel_hour", field_sel, 1);
    check("cap_values", ld_now(), pack_date(59, 59, 23, 31, 12, 9999));
    check_blink("blink_hour");
    press(1'b0, 1'b1);
    check("wrap_hour", bus.ld_hour, 0);
    press(1'b1, 1'b0);
    check("cap_sel_min", field_sel, 2);
    press(1'b0, 1'b1);
    check("wrap_min", bus.ld_min, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("wrap_sec", bus.ld_sec, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("wrap_year", bus.ld_year, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("wrap_month", bus.ld_month, 1);
    press(1'b1, 1'b0);
    check("noclamp_day", bus.ld_day, 31);
    press(1'b0, 1'b1);
    check("wrap_day", bus.ld_day, 1);
    exp_q.push_back(pack_date(0, 0, 0, 1, 1, 0));
    press(1'b1, 1'b0);
    check("wrap_commit_load", bus.load, 1);
    check("commit_sel", field_sel, 0);
    count_to_tick("commit_tick_first");
    count_to_tick("commit_tick_period");

    clamp_case(2023, 28);
    clamp_case(2024, 29);

    // Simultaneous buttons in SET_MIN, then a long inc hold in SET_SEC.
    set_cur(5, 17, 42, 15, 6, 2030);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("both_pre_sel", field_sel, 2);
    press(1'b1, 1'b1);
    check("both_sel", field_sel, 3);
    check("both_min_kept", bus.ld_min, 17);
    check_blink("blink_sec");
    @(negedge clk);
    inc = 1'b1;
    repeat (20) @(negedge clk);
    inc = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_one_inc", bus.ld_sec, 43);
    repeat (3) press(1'b1, 1'b0);
    check("hold_day_kept", bus.ld_day, 15);
    exp_q.push_back(pack_date(43, 17, 5, 15, 6, 2030));
    press(1'b1, 1'b0);
    check("hold_commit_load", bus.load, 1);
    count_to_tick("commit_tick_first");

    // Reset while editing the month: edits must be discarded.
    set_cur(8, 9, 10, 11, 3, 2031);
    repeat (5) press(1'b1, 1'b0);
    check("mid_sel_month", field_sel, 5);
    press(1'b0, 1'b1);
    check("mid_month_inc", bus.ld_month, 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", field_sel, 0);
    check("mid_rst_blink", blink, 0);
    check("mid_rst_load", bus.load, 0);
    check("mid_rst_tick", bus.tick_en, 0);
    check("mid_rst_ld", ld_now(), pack_date(0, 0, 0, 1, 1, 2024));
    exp_q.push_back(pack_date(0, 0, 0, 1, 1, 2024));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_init_load", bus.load, 1);
    count_to_tick("mid_init_tick");

    repeat (8) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
